ecm_ladder_seq: RTL and testbench

Sequencer that drives one `mont_ladder` instance for a scalar multiplication. It reads the scalar k word-by-word from the scalar SRAM, most-significant word first, and strips leading zeros and the leading one. It then launches the ladder and streams the remaining bits of k over the ladder's `k_req/k_val/k_bit/k_last` handshake. It sits between the ECM stage-1 top control and the ladder, and reports completion or a malformed scalar.

---
 rtl/ecm_pkg.sv | 24 ++
 rtl/msb_finder.sv | 27 ++
 rtl/ecm_ladder_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_ecm_ladder_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecm_pkg.sv
// ecm_pkg: definitions shared across the ECM stage-1 blocks.
//   ECM_WORD_WIDTH     : default scalar SRAM word width
//   ECM_ADDR_WIDTH     : default scalar SRAM address width
//   ladder_seq_state_t : state encoding of ecm_ladder_seq, also visible on
//                        its dbg_state output
package ecm_pkg;

    localparam int ECM_WORD_WIDTH = 32;
    localparam int ECM_ADDR_WIDTH = 8;

    typedef enum logic [3:0] {
        LS_IDLE      = 4'd0,
        LS_RD        = 4'd1,
        LS_LOAD      = 4'd2,
        LS_SCAN      = 4'd3,
        LS_LAUNCH    = 4'd4,
        LS_STREAM    = 4'd5,
        LS_REFILL_RD = 4'd6,
        LS_REFILL_LD = 4'd7,
        LS_WAIT_LDR  = 4'd8,
        LS_FIN       = 4'd9
    } ladder_seq_state_t;

endpackage

// File: rtl/msb_finder.sv
// msb_finder: combinational priority encoder returning the index of the
// highest set bit of a word.
//   word : input word
//   pos  : index of the most significant 1 (0 when word is zero)
//   zero : 1 when word has no bit set
module msb_finder #(
    parameter int WIDTH = 32,
    localparam int PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] word,
    output logic [PW-1:0]    pos,
    output logic             zero
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (word[i]) begin
                pos = PW'(i);
            end
        end
    end

    assign zero = ~|word;

endmodule

// File: rtl/ecm_ladder_seq.sv
// ecm_ladder_seq: feeds the scalar k, read MSW-first from the scalar SRAM,
// to one mont_ladder. Leading zeros and the leading one of k are stripped;
// the remaining bits are streamed over k_req/k_val/k_bit/k_last.
//
// Optional feature macro: ECM_LADDER_SEQ_PREFETCH_EN
//   defined   : a one-word prefetch buffer hides the refill bubble
//   undefined : words after the first are fetched via REFILL_RD/REFILL_LD
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   start          : command pulse, honoured only while idle
//   k_base,k_words : address of the MSW of k, number of words (0 illegal)
//   busy,done,err  : status; err is valid with the done pulse
//   mem_rd,mem_addr,mem_rdata : scalar SRAM port, data 1 cycle after mem_rd
//   ladder_start,ladder_ready : ladder launch pulse / ladder completion pulse
//   k_req,k_val,k_bit,k_last  : bit handoff to the ladder
//   dbg_state      : current FSM state
//
// Bit handshake: a bit moves on a cycle where k_req and k_val are both high
// at the clock edge. k_val is a combinational function of k_req; the ladder
// drops k_req after each accepted bit, so each bit is handed over once.
module ecm_ladder_seq
    import ecm_pkg::*;
#(
    parameter int NUM_WIDTH  = 256,
    parameter int WORD_WIDTH = ECM_WORD_WIDTH,
    parameter int ADDR_WIDTH = ECM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] k_base,
    input  logic [ADDR_WIDTH-1:0] k_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  ladder_start,
    input  logic                  ladder_ready,
    input  logic                  k_req,
    output logic                  k_val,
    output logic                  k_bit,
    output logic                  k_last,
    output logic [3:0]            dbg_state
);

    localparam int PTR_W = $clog2(WORD_WIDTH);

    // NUM_WIDTH belongs to the ladder; it is only sanity-checked here.
    if (NUM_WIDTH < 2 || WORD_WIDTH < 2 || (WORD_WIDTH & (WORD_WIDTH - 1)) != 0) begin : g_param_check
        $error("ecm_ladder_seq: WORD_WIDTH must be a power of two and NUM_WIDTH >= 2");
    end

    ladder_seq_state_t     r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_words_left;
    logic [WORD_WIDTH-1:0] r_cur_word;
    logic [PTR_W-1:0]      r_ptr;
    logic                  r_ptr_vld;
    logic                  r_err;

    logic [PTR_W-1:0]      w_pos;
    logic                  w_zero;
    logic                  w_stream;
    logic                  w_take;
    logic                  w_more;

    msb_finder #(.WIDTH(WORD_WIDTH)) u_msb_finder (
        .word (r_cur_word),
        .pos  (w_pos),
        .zero (w_zero)
    );

    assign w_stream = (r_state == LS_STREAM);

`ifdef ECM_LADDER_SEQ_PREFETCH_EN
    logic [WORD_WIDTH-1:0] r_nxt_word;
    logic                  r_nxt_vld;
    logic                  r_pf_pend;
    logic                  w_pf_issue;
    logic                  w_swap;

    // Fetch ahead once the ladder is being launched; one word in flight or
    // buffered at a time.
    assign w_pf_issue = ((r_state == LS_LAUNCH) || w_stream) && (r_words_left != '0)
                        && !r_nxt_vld && !r_pf_pend;
    // Words still to come include the buffered and the in-flight one.
    assign w_more     = (r_words_left != '0) || r_nxt_vld || r_pf_pend;
    // Current word runs out (now or already): take the buffered word in place.
    assign w_swap     = w_stream && r_nxt_vld
                        && (!r_ptr_vld || (w_take && (r_ptr == '0)));
    assign mem_rd     = (r_state == LS_RD) || w_pf_issue;
`else
    assign w_more     = (r_words_left != '0);
    assign mem_rd     = (r_state == LS_RD) || (r_state == LS_REFILL_RD);
`endif

    assign mem_addr     = mem_rd ? r_addr : '0;
    assign busy         = (r_state != LS_IDLE);
    assign done         = (r_state == LS_FIN);
    assign err          = done & r_err;
    assign ladder_start = (r_state == LS_LAUNCH);
    assign k_val        = w_stream & k_req & r_ptr_vld;
    assign k_bit        = w_stream & r_cur_word[r_ptr];
    assign k_last       = w_stream & r_ptr_vld & (r_ptr == '0) & !w_more;
    assign w_take       = k_val;
    assign dbg_state    = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LS_IDLE;
            r_addr       <= '0;
            r_words_left <= '0;
            r_cur_word   <= '0;
            r_ptr        <= '0;
            r_ptr_vld    <= 1'b0;
            r_err        <= 1'b0;
`ifdef ECM_LADDER_SEQ_PREFETCH_EN
            r_nxt_word   <= '0;
            r_nxt_vld    <= 1'b0;
            r_pf_pend    <= 1'b0;
`endif
        end else begin
            case (r_state)
                LS_IDLE: begin
                    if (start) begin
                        r_addr       <= k_base;
                        r_words_left <= k_words;
                        r_err        <= (k_words == '0);
                        r_state      <= (k_words == '0) ? LS_FIN : LS_RD;
                    end
                end
                LS_RD: begin
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_words_left <= r_words_left - ADDR_WIDTH'(1);
                    r_state      <= LS_LOAD;
                end
                LS_LOAD: begin
                    r_cur_word <= mem_rdata;
                    r_state    <= LS_SCAN;
                end
                LS_SCAN: begin
                    if (w_zero) begin
                        if (r_words_left != '0) begin
                            r_state <= LS_RD;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= LS_FIN;
                        end
                    end else if ((w_pos == '0) && (r_words_left == '0)) begin
                        // k == 1: nothing left after the leading one
                        r_err   <= 1'b1;
                        r_state <= LS_FIN;
                    end else begin
                        // ptr_vld=0 when the leading one was bit 0: the
                        // stream starts with a refill.
                        r_ptr     <= w_pos - PTR_W'(1);
                        r_ptr_vld <= (w_pos != '0);
                        r_state   <= LS_LAUNCH;
                    end
                end
                LS_LAUNCH: begin
                    r_state <= LS_STREAM;
                end
                LS_STREAM: begin
                    if (w_take && k_last) begin
                        r_state <= LS_WAIT_LDR;
                    end else if (w_take && (r_ptr != '0)) begin
                        r_ptr <= r_ptr - PTR_W'(1);
                    end else begin
`ifdef ECM_LADDER_SEQ_PREFETCH_EN
                        if (w_swap) begin
                            r_cur_word <= r_nxt_word;
                            r_ptr      <= '1;
                            r_ptr_vld  <= 1'b1;
                        end else if (w_take) begin
                            r_ptr_vld  <= 1'b0;
                        end
`else
                        if (w_take) begin
                            r_ptr_vld <= 1'b0;
                        end else if (!r_ptr_vld && w_more) begin
                            r_state <= LS_REFILL_RD;
                        end
`endif
                    end
                end
`ifndef ECM_LADDER_SEQ_PREFETCH_EN
                LS_REFILL_RD: begin
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_words_left <= r_words_left - ADDR_WIDTH'(1);
                    r_state      <= LS_REFILL_LD;
                end
                LS_REFILL_LD: begin
                    r_cur_word <= mem_rdata;
                    r_ptr      <= '1;
                    r_ptr_vld  <= 1'b1;
                    r_state    <= LS_STREAM;
                end
`endif
                LS_WAIT_LDR: begin
                    if (ladder_ready) begin
                        r_err   <= 1'b0;
                        r_state <= LS_FIN;
                    end
                end
                LS_FIN: begin
                    r_state <= LS_IDLE;
                end
                default: begin
                    r_state <= LS_IDLE;
                end
            endcase

`ifdef ECM_LADDER_SEQ_PREFETCH_EN
            // Prefetch pipeline runs beside the FSM; its address/count
            // updates never coincide with RD (different states).
            if (w_pf_issue) begin
                r_addr       <= r_addr + ADDR_WIDTH'(1);
                r_words_left <= r_words_left - ADDR_WIDTH'(1);
            end
            r_pf_pend <= w_pf_issue;
            if (r_pf_pend) begin
                r_nxt_word <= mem_rdata;
                r_nxt_vld  <= 1'b1;
            end else if (w_swap) begin
                r_nxt_vld  <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ecm_ladder_seq.sv
// tb_ecm_ladder_seq: randomized bench for ecm_ladder_seq with an SRAM model,
// a model ladder that requests bits with random gaps, and a scoreboard fed
// from a bit-list model of the scalar-stripping rules.
module tb_ecm_ladder_seq;
    import ecm_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  k_base;
    logic [7:0]  k_words;
    logic        busy, done, err, mem_rd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        ladder_start, ladder_ready;
    logic        k_req, k_val, k_bit, k_last;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    ecm_ladder_seq #(.NUM_WIDTH(256), .WORD_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_base       (k_base),
        .k_words      (k_words),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .ladder_start (ladder_start),
        .ladder_ready (ladder_ready),
        .k_req        (k_req),
        .k_val        (k_val),
        .k_bit        (k_bit),
        .k_last       (k_last),
        .dbg_state    (dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  exp_q[$];      // {bit, last}
    logic        err_q[$];
    int          start_q[$];
    int          reads_q[$];
    int          lstart_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          bits_seen = 0;
    int          lad_gap_max = 0;
    bit          lad_abort = 1'b0;
    bit          lad_busy = 1'b0;
    logic [31:0] wbuf [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                lstart_cnt = 0;
                rd_cnt = 0;
            end else begin
                if (ladder_start) lstart_cnt++;
                if (mem_rd) rd_cnt++;
                if (k_req && k_val) begin
                    bits_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_bit: got bit=%0b last=%0b with nothing expected", k_bit, k_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bit_last", {30'd0, k_bit, k_last}, {30'd0, e});
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (err_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_done: got done with no command outstanding");
                    end else begin
                        chk("err", {31'd0, err}, {31'd0, err_q.pop_front()});
                        chk("ladder_starts", lstart_cnt, start_q.pop_front());
                        chk("sram_reads", rd_cnt, reads_q.pop_front());
                        chk("bits_remaining", exp_q.size(), 0);
                        exp_q.delete();
                    end
                    lstart_cnt = 0;
                    rd_cnt = 0;
                end
            end
        end
    end

    // ---------------- model ladder ----------------
    initial begin
        int g, tmo, d;
        bit got, last, fin;
        k_req = 1'b0;
        ladder_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (ladder_start && !rst) begin
                lad_busy = 1'b1;
                fin = 1'b0;
                while (!fin && !lad_abort) begin
                    g = $urandom_range(0, lad_gap_max);
                    for (int j = 0; j < g && !lad_abort; j++) @(negedge clk);
                    k_req = 1'b1;
                    got = 1'b0;
                    tmo = 0;
                    while (!got && !lad_abort && tmo < 2000) begin
                        #1;
                        if (k_val) begin
                            got = 1'b1;
                            last = k_last;
                        end
                        @(negedge clk);
                        tmo++;
                    end
                    k_req = 1'b0;
                    if (!got && !lad_abort) begin
                        checks++;
                        failures++;
                        $display("FAIL ladder_bit_timeout: got no k_val within %0d cycles, required a bit", tmo);
                        fin = 1'b1;
                    end else if (got && last) begin
                        fin = 1'b1;
                        d = $urandom_range(1, 5);
                        for (int j = 0; j < d && !lad_abort; j++) @(negedge clk);
                        if (!lad_abort) begin
                            ladder_ready = 1'b1;
                            @(negedge clk);
                            ladder_ready = 1'b0;
                        end
                    end
                end
                lad_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_case(input logic [7:0] base, input int nw, input int gap_max);
        logic [1:0] bits[$];
        logic [1:0] lastb;
        bit         found;
        logic       v;
        found = 1'b0;
        for (int i = 0; i < nw; i++) mem[8'(base + i)] = wbuf[i];
        // k as a bit string MSB first; drop leading zeros and the leading one
        for (int w = 0; w < nw; w++) begin
            for (int b = 31; b >= 0; b--) begin
                v = wbuf[w][b];
                if (found) bits.push_back({v, 1'b0});
                else if (v) found = 1'b1;
            end
        end
        if (bits.size() == 0) begin
            err_q.push_back(1'b1);
            start_q.push_back(0);
        end else begin
            lastb = bits.pop_back();
            bits.push_back({lastb[1], 1'b1});
            foreach (bits[i]) exp_q.push_back(bits[i]);
            err_q.push_back(1'b0);
            start_q.push_back(1);
        end
        reads_q.push_back(nw);
        lad_gap_max = gap_max;
        @(negedge clk);
        k_base = base;
        k_words = 8'(nw);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_case(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles, required one", t);
        end
        repeat (10) @(negedge clk);
        #3;
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_case(input logic [7:0] base, input int nw, input int gap_max, input bit poke_wait);
        int d0, t;
        d0 = done_cnt;
        issue_case(base, nw, gap_max);
        if (poke_wait) begin
            t = 0;
            while (dbg_state != LS_WAIT_LDR && t < 20000) begin
                @(negedge clk);
                t++;
            end
            if (dbg_state != LS_WAIT_LDR) begin
                checks++;
                failures++;
                $display("FAIL wait_ldr_timeout: got state %0d, required WAIT_LDR", dbg_state);
            end
            k_base = 8'hF0;
            k_words = 8'd1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_case(d0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'h1 << $urandom_range(0, 31);
            2: return $urandom;
            default: return 32'h8000_0000;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int t, b0;
        rst = 1'b1;
        start = 1'b0;
        k_base = 8'h0;
        k_words = 8'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_ladder_start", {31'd0, ladder_start}, 0);
        chk("rst_k_val", {31'd0, k_val}, 0);
        chk("rst_k_bit", {31'd0, k_bit}, 0);
        chk("rst_k_last", {31'd0, k_last}, 0);
        @(negedge clk);
        rst = 1'b0;

        // k = 2: one bit, value 0, last
        wbuf[0] = 32'h2;
        run_case(8'h10, 1, 3, 1'b0);
        // k = 0 over three words
        wbuf[0] = 32'h0; wbuf[1] = 32'h0; wbuf[2] = 32'h0;
        run_case(8'h20, 3, 3, 1'b0);
        // k = 1, single and multi-word
        wbuf[0] = 32'h1;
        run_case(8'h30, 1, 3, 1'b0);
        wbuf[0] = 32'h0; wbuf[1] = 32'h0; wbuf[2] = 32'h1;
        run_case(8'h38, 3, 3, 1'b0);
        // k_words = 0
        run_case(8'h40, 0, 3, 1'b0);
        // leading one at bit 0 of the first word: 32 bits, 1 then zeros
        wbuf[0] = 32'h1; wbuf[1] = 32'h8000_0000;
        run_case(8'h48, 2, 5, 1'b0);
        // leading zero words, leading one at bit 0, two more words
        wbuf[0] = 32'h0; wbuf[1] = 32'h1; wbuf[2] = 32'h5; wbuf[3] = $urandom;
        run_case(8'h50, 4, 2, 1'b0);

        // random 4-word k with 0..20 cycle request gaps
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            run_case(8'($urandom_range(0, 250)), 4, 20, 1'b0);
        end

        // random lengths and sparse words, short gaps
        for (int r = 0; r < 10; r++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++) wbuf[i] = rand_word();
            run_case(8'($urandom_range(0, 248)), nw, 3, 1'b0);
        end

        // reset in the middle of STREAM, then a fresh command elsewhere
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom | 32'h8000_0000;
        b0 = bits_seen;
        issue_case(8'h60, 4, 6);
        t = 0;
        while (bits_seen < b0 + 8 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_progress", {31'd0, (bits_seen >= b0 + 8)}, 1);
        lad_abort = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        err_q.delete();
        start_q.delete();
        reads_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post_rst_k_val", {31'd0, k_val}, 0);
        chk("post_rst_busy", {31'd0, busy}, 0);
        t = 0;
        while (lad_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        lad_abort = 1'b0;
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        wbuf[0] = wbuf[0] | 32'h0000_0100;
        run_case(8'hA0, 3, 4, 1'b0);

        // start pulsed while waiting for the ladder: ignored
        wbuf[0] = $urandom | 32'h1000; wbuf[1] = $urandom;
        run_case(8'hC0, 2, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: got no end of sequence by %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
